// File: rtl/pc_ctrl.sv
// Program-counter controller: prioritised next-PC selection (trap, stall,
// return, jump/call, branch, sequential) with a circular return-address stack.
module pc_ctrl #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(32'h0000_0100),
  parameter int unsigned       STEP      = 4,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              call,
  input  logic              ret,
  input  logic              trap,
  output logic [ADDR_W-1:0] pc,
  output logic              redirect,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);

  localparam int unsigned       PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned       CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);

  if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pc_ctrl: RAS_DEPTH must be a power of two and at least 2");
  end

  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] pc_nxt, seq_pc, top;
  logic              redirect_nxt, err_nxt, push, pop, flush;

  assign seq_pc = pc + STEP_V;
  // ptr points at the next free slot; the top of stack sits just below it
  assign top    = ras[ptr - PTR_W'(1)];

  // Next-PC selection in fixed priority order
  always_comb begin
    pc_nxt       = seq_pc;
    redirect_nxt = 1'b0;
    err_nxt      = ras_err;
    push         = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;
    if (trap) begin
      pc_nxt       = TRAP_VEC;
      redirect_nxt = 1'b1;
      flush        = 1'b1;
    end else if (stall) begin
      pc_nxt       = pc;
    end else if (ret) begin
      if (cnt != '0) begin
        pc_nxt       = top;
        redirect_nxt = 1'b1;
        pop          = 1'b1;
      end else begin
        err_nxt      = 1'b1;
      end
    end else if (jmp_en) begin
      pc_nxt       = jmp_target;
      redirect_nxt = 1'b1;
      push         = call;
    end else if (br_taken) begin
      pc_nxt       = pc + br_offset;
      redirect_nxt = 1'b1;
    end
  end

  // Stack pointer wraps freely so a push to a full stack overwrites the oldest entry
  always_comb begin
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    if (flush) begin
      ptr_nxt = '0;
      cnt_nxt = '0;
    end else if (push) begin
      ptr_nxt = ptr + PTR_W'(1);
      if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
    end else if (pop) begin
      ptr_nxt = ptr - PTR_W'(1);
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_VEC;
      redirect  <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
      ras_empty <= 1'b1;
      ras_full  <= 1'b0;
      ras_err   <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      redirect  <= redirect_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      ras_empty <= (cnt_nxt == '0);
      ras_full  <= (cnt_nxt == CNT_MAX);
      ras_err   <= err_nxt;
    end
  end

  // Stack storage needs no reset: occupancy count alone decides validity
  always_ff @(posedge clk) begin
    if (push) ras[ptr] <= seq_pc;
  end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the PC and address width in bits.
REQ-002 Parameter RESET_VEC, default 0, SHALL set the PC value loaded on reset.
REQ-003 Parameter TRAP_VEC, default 32'h0000_0100, SHALL set the PC value loaded on trap.
REQ-004 Parameter STEP, default 4, SHALL set the sequential increment.
REQ-005 Parameter RAS_DEPTH, default 4, SHALL set the return-address-stack entry count; it SHALL be a power of two and at least 2.
REQ-006 The port list SHALL be:
  clk  in  1  clock, rising edge.
  reset  in  1  asynchronous, active-high.
  stall  in  1  hold PC and RAS.
  br_taken  in  1  relative branch request.
  br_offset  in  ADDR_W  two's-complement branch offset.
  jmp_en  in  1  absolute jump request.
  jmp_target  in  ADDR_W  absolute jump address.
  call  in  1  link qualifier, valid only with jmp_en.
  ret  in  1  return request (pop RAS).
  trap  in  1  trap request.
  pc  out  ADDR_W  current PC, registered.
  redirect  out  1  registered; 1 when the last PC update was non-sequential.
  ras_empty  out  1  RAS holds 0 entries.
  ras_full  out  1  RAS holds RAS_DEPTH entries.
  ras_err  out  1  sticky; return underflow seen.

Function
REQ-007 The PC SHALL update only on rising clk; a request sampled at edge N SHALL be visible on pc after edge N.
REQ-008 Next-PC selection SHALL use this fixed priority: trap > stall > ret > jmp_en > br_taken > sequential.
REQ-009 On trap, pc SHALL be set to TRAP_VEC, the RAS SHALL be flushed to empty, and redirect SHALL be 1; trap SHALL override stall.
REQ-010 On stall with no trap, pc, the RAS and ras_err SHALL hold; redirect SHALL be 0.
REQ-011 On ret with a non-empty RAS, pc SHALL be set to the top entry, the top entry SHALL be popped, and redirect SHALL be 1.
REQ-012 On ret with an empty RAS, pc SHALL be set to pc+STEP, ras_err SHALL be set to 1, and redirect SHALL be 0.
REQ-013 On jmp_en, pc SHALL be set to jmp_target and redirect SHALL be 1; if call=1, pc+STEP (old pc) SHALL be pushed in the same cycle.
REQ-014 On a push to a full RAS, the oldest entry SHALL be overwritten (circular), and ras_full SHALL remain 1.
REQ-015 On br_taken, pc SHALL be set to pc+br_offset (signed) and redirect SHALL be 1.
REQ-016 With no request asserted, pc SHALL be set to pc+STEP and redirect SHALL be 0.
REQ-017 call without jmp_en SHALL be ignored; when ret and jmp_en+call are both asserted, ret SHALL win and no push SHALL occur.
REQ-018 All PC arithmetic SHALL be modulo 2^ADDR_W, wrapping silently, with no alignment forcing.
REQ-019 The RAS occupancy count SHALL saturate at RAS_DEPTH and floor at 0; ras_empty and ras_full SHALL be derived from this count, registered.
REQ-020 ras_err SHALL clear only on reset.

Reset
REQ-021 Asserting reset SHALL immediately set pc=RESET_VEC, redirect=0, ras_empty=1, ras_full=0, ras_err=0, and RAS count=0, independent of clk.
REQ-022 Reset asserted mid-operation SHALL discard all pending requests and all RAS contents.
REQ-023 After reset deasserts, the first clk edge SHALL apply normal selection starting from RESET_VEC.

Verification
REQ-024 Reset release, then 3 idle cycles -> pc = 0, 4, 8, 12 and redirect = 0 throughout.
REQ-025 At pc=0x40: br_taken with offset 0xFFFF_FFF0 -> pc=0x30 and redirect=1; then at pc=0x30, stall for 2 cycles -> pc holds 0x30.
REQ-026 At pc=0x100: jmp_en+call to 0x800 -> pc=0x800 and RAS top=0x104; ret -> pc=0x104 and ras_empty=1.
REQ-027 Five calls from pc=0x10, 0x20, 0x30, 0x40, 0x50 with RAS_DEPTH=4 -> ras_full=1; four rets return 0x54, 0x44, 0x34, 0x24; a fifth ret -> pc+4 and ras_err=1.
REQ-028 trap asserted together with stall and ret at pc=0x500 -> pc=0x100, ras_empty=1, redirect=1.
REQ-029 At pc=0xFFFF_FFFC, idle -> pc=0x0 (wrap); reset pulsed mid-cycle -> pc=0 immediately, before the next clk edge.
